// File: rtl/dvi_timing_ctrl_if.sv
// Pixel-side bus of the DVI timing controller: pixel FIFO read handshake,
// run control, underflow status and the sync/RGB outputs to the TMDS stage.
// Optional macro DVI_TESTPAT_EN adds the iTESTPAT colour-bar request.
interface dvi_timing_ctrl_if;
    logic        iEN;
    logic [23:0] iPIX_DATA;
    logic        iPIX_VALID;
    logic        oPIX_RD;
    logic        oSOF;
    logic [7:0]  oRED;
    logic [7:0]  oGRN;
    logic [7:0]  oBLU;
    logic        oHS;
    logic        oVS;
    logic        oDE;
    logic        oUNDERFLOW;
    logic        iUNDERFLOW_CLR;
    logic        oBUSY;
`ifdef DVI_TESTPAT_EN
    logic        iTESTPAT;

    modport master (
        input  iEN, iPIX_DATA, iPIX_VALID, iUNDERFLOW_CLR, iTESTPAT,
        output oPIX_RD, oSOF, oRED, oGRN, oBLU, oHS, oVS, oDE, oUNDERFLOW, oBUSY
    );
    modport slave (
        output iEN, iPIX_DATA, iPIX_VALID, iUNDERFLOW_CLR, iTESTPAT,
        input  oPIX_RD, oSOF, oRED, oGRN, oBLU, oHS, oVS, oDE, oUNDERFLOW, oBUSY
    );
`else
    modport master (
        input  iEN, iPIX_DATA, iPIX_VALID, iUNDERFLOW_CLR,
        output oPIX_RD, oSOF, oRED, oGRN, oBLU, oHS, oVS, oDE, oUNDERFLOW, oBUSY
    );
    modport slave (
        output iEN, iPIX_DATA, iPIX_VALID, iUNDERFLOW_CLR,
        input  oPIX_RD, oSOF, oRED, oGRN, oBLU, oHS, oVS, oDE, oUNDERFLOW, oBUSY
    );
`endif
endinterface

// File: rtl/dvi_timing_ctrl.sv
// Video timing controller and pixel sequencer for the DVI/TMDS output stage.
// Generates HS/VS/DE and 24-bit RGB from programmable timing, pops pixels
// from a show-ahead FIFO, pulses oSOF one cycle before each frame's (0,0),
// flags FIFO underflow (sticky) and only starts/stops on frame boundaries.
// Optional macro DVI_TESTPAT_EN: adds iTESTPAT, which replaces FIFO pixels
// with eight vertical colour bars for a whole frame.
module dvi_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    dvi_timing_ctrl_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_C    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_C    = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START_C = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END_C   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] VS_START_C = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END_C   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;

    state_t          state_reg, state_next;
    logic [H_W-1:0]  hcnt_reg, hcnt_next;
    logic [V_W-1:0]  vcnt_reg, vcnt_next;
    logic            sof;
    logic            frame_end;
    logic            running;
    logic            de_c, hs_c, vs_c;
    logic            tp_on;
    logic            pix_rd;
    logic            underflow_set;
    logic [23:0]     rgb_next;

    logic            de_reg, hs_reg, vs_reg, und_reg;
    logic [23:0]     rgb_reg;

    assign running   = (state_reg == RUN) || (state_reg == STOP);
    assign frame_end = (hcnt_reg == H_LAST) && (vcnt_reg == V_LAST);

    // Next state and start-of-frame pulse; stop requests take effect only at frame end
    always_comb begin
        state_next = state_reg;
        sof        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.iEN) state_next = ARM;
            end
            ARM: begin
                sof        = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (frame_end) sof = 1'b1;
                if (!bus.iEN) state_next = STOP;
            end
            STOP: begin
                if (frame_end) begin
                    if (bus.iEN) begin
                        sof        = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Raster counters: free-run while a frame is in progress, parked at (0,0) otherwise
    always_comb begin
        hcnt_next = '0;
        vcnt_next = '0;
        if (running) begin
            if (hcnt_reg == H_LAST) begin
                hcnt_next = '0;
                vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
            end else begin
                hcnt_next = hcnt_reg + 1'b1;
                vcnt_next = vcnt_reg;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_reg <= IDLE;
            hcnt_reg  <= '0;
            vcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            vcnt_reg  <= vcnt_next;
        end
    end

    // Region decode; regions are only live while a frame is running
    assign de_c = running && (hcnt_reg < H_ACT_C) && (vcnt_reg < V_ACT_C);
    assign hs_c = running && (hcnt_reg >= HS_START_C) && (hcnt_reg < HS_END_C);
    assign vs_c = running && (vcnt_reg >= VS_START_C) && (vcnt_reg < VS_END_C);

`ifdef DVI_TESTPAT_EN
    localparam int             BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [H_W-1:0] BAR_W_C = H_W'(BAR_W);

    logic           tp_reg;
    logic [H_W-1:0] bar_pos;
    logic [2:0]     bar_idx;
    logic [23:0]    bar_rgb;

    // Test pattern request latched at frame start and held for the whole frame
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            tp_reg <= 1'b0;
        end else if (sof) begin
            tp_reg <= bus.iTESTPAT;
        end
    end

    // Bar colour: bits of the bar index select which components are off
    // (white, yellow, cyan, green, magenta, red, blue, black)
    always_comb begin
        bar_pos = hcnt_reg / BAR_W_C;
        bar_idx = (bar_pos > H_W'(7)) ? 3'd7 : bar_pos[2:0];
        bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    end

    assign tp_on = tp_reg;
`else
    assign tp_on = 1'b0;
`endif

    // FIFO pop and underflow detection happen in the same cycle the pixel is sampled
    assign pix_rd        = de_c && bus.iPIX_VALID && !tp_on;
    assign underflow_set = de_c && !bus.iPIX_VALID && !tp_on;

    // Pixel selection: blank outside DE, black on underflow
    always_comb begin
        rgb_next = 24'h000000;
        if (de_c) begin
`ifdef DVI_TESTPAT_EN
            if (tp_on) begin
                rgb_next = bar_rgb;
            end else
`endif
            if (bus.iPIX_VALID) begin
                rgb_next = bus.iPIX_DATA;
            end
        end
    end

    // Output registers: one cycle behind the counters
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            de_reg  <= 1'b0;
            hs_reg  <= ~HS_POL;
            vs_reg  <= ~VS_POL;
            rgb_reg <= 24'h000000;
        end else begin
            de_reg  <= de_c;
            hs_reg  <= hs_c ? HS_POL : ~HS_POL;
            vs_reg  <= vs_c ? VS_POL : ~VS_POL;
            rgb_reg <= rgb_next;
        end
    end

    // Sticky underflow flag; a new underflow beats a concurrent clear
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            und_reg <= 1'b0;
        end else if (underflow_set) begin
            und_reg <= 1'b1;
        end else if (bus.iUNDERFLOW_CLR) begin
            und_reg <= 1'b0;
        end
    end

    // Split the registered pixel into the three TMDS channels (R, G, B)
    logic [7:0] chan [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = rgb_reg[23 - 8*gi -: 8];
        end
    endgenerate

    assign bus.oRED       = chan[0];
    assign bus.oGRN       = chan[1];
    assign bus.oBLU       = chan[2];
    assign bus.oDE        = de_reg;
    assign bus.oHS        = hs_reg;
    assign bus.oVS        = vs_reg;
    assign bus.oUNDERFLOW = und_reg;
    assign bus.oPIX_RD    = pix_rd;
    assign bus.oSOF       = sof;
    assign bus.oBUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Self-checking bench for dvi_timing_ctrl on a reduced raster (16x6 active,
// 24x10 total). A frame-position reference model predicts every cycle's
// outputs; registered outputs go through a scoreboard queue checked by a
// separate monitor, combinational outputs are checked as they are produced.
module tb_dvi_timing_ctrl;

    localparam int HA  = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA  = 6,  VFP = 1, VSY = 2, VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dvi_timing_ctrl_if bus_if();

    dvi_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .iCLK   (clk),
        .iRESETn(rst_n),
        .bus    (bus_if)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
        logic        und;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   started = 0;

    // stimulus variables
    logic        rst_v = 1'b0, en_v = 1'b0, valid_v = 1'b1, clr_v = 1'b0, tp_v = 1'b0;
    logic [23:0] head = 24'h0;
    bit          pop_pending = 0;

    // reference model: where in the frame we are, and the run mode
    bit m_idle = 1, m_arm = 0, m_stop = 0, m_tp = 0, m_und = 0;
    int m_pos  = 0;
    int frame_no = 0;

    // aggregate frame checks
    int rd_cnt = 0;
    bit frame_clean = 0;
    int prev_sof = 0;
    bit have_prev_sof = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] bar_color(input int x);
        int b;
        b = x / (HA / 8);
        if (b > 7) b = 7;
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model_reset();
        m_idle = 1; m_arm = 0; m_stop = 0; m_tp = 0; m_und = 0; m_pos = 0;
        rd_cnt = 0; frame_clean = 0; have_prev_sof = 0;
    endtask

    // Predict this cycle's combinational outputs and the registered outputs after the next edge
    task automatic model_eval();
        exp_t e;
        int x, y;
        bit act, in_de, last, e_sof, e_rd;
        logic [23:0] pix;
        cyc++;
        started = 1;
        if (!rst_n) begin
            check("rst_de",   bus_if.oDE, 0);
            check("rst_hs",   bus_if.oHS, !HS_POL);
            check("rst_vs",   bus_if.oVS, !VS_POL);
            check("rst_rgb",  {bus_if.oRED, bus_if.oGRN, bus_if.oBLU}, 0);
            check("rst_rd",   bus_if.oPIX_RD, 0);
            check("rst_sof",  bus_if.oSOF, 0);
            check("rst_und",  bus_if.oUNDERFLOW, 0);
            check("rst_busy", bus_if.oBUSY, 0);
            model_reset();
            e.de = 0; e.hs = !HS_POL; e.vs = !VS_POL; e.rgb = 0; e.und = 0;
            exp_q.push_back(e);
            return;
        end
        act   = !m_idle && !m_arm;
        x     = m_pos % HT;
        y     = m_pos / HT;
        in_de = act && (x < HA) && (y < VA);
        last  = act && (m_pos == FRAME - 1);
        e_sof = m_arm || (last && (!m_stop || bus_if.iEN));
        e_rd  = in_de && bus_if.iPIX_VALID && !m_tp;

        check("pix_rd", bus_if.oPIX_RD, e_rd);
        check("sof",    bus_if.oSOF, e_sof);
        check("busy",   bus_if.oBUSY, !m_idle);

        if (bus_if.oSOF) begin
            if (have_prev_sof && !m_arm) check("sof_period", cyc - prev_sof, FRAME);
            prev_sof = cyc;
            have_prev_sof = 1;
        end
        if (bus_if.oPIX_RD) rd_cnt++;
        if (in_de && (!bus_if.iPIX_VALID || m_tp)) frame_clean = 0;
        pop_pending = bus_if.oPIX_RD;

        if (!in_de)                 pix = 24'h0;
        else if (m_tp)              pix = bar_color(x);
        else if (bus_if.iPIX_VALID) pix = bus_if.iPIX_DATA;
        else                        pix = 24'h0;

        e.de  = in_de;
        e.hs  = (act && x >= HA + HFP && x < HA + HFP + HSY) ? HS_POL : !HS_POL;
        e.vs  = (act && y >= VA + VFP && y < VA + VFP + VSY) ? VS_POL : !VS_POL;
        e.rgb = pix;
        if (in_de && !bus_if.iPIX_VALID && !m_tp) m_und = 1;
        else if (bus_if.iUNDERFLOW_CLR)           m_und = 0;
        e.und = m_und;
        exp_q.push_back(e);

        if (last) begin
            if (frame_clean) check("rd_per_frame", rd_cnt, HA * VA);
            frame_no++;
            $display("frame %0d done at cycle %0d: pops=%0d underflow=%0d tp=%0d",
                     frame_no, cyc, rd_cnt, m_und, m_tp);
            rd_cnt = 0;
            frame_clean = 1;
        end

`ifdef DVI_TESTPAT_EN
        if (e_sof) m_tp = bus_if.iTESTPAT;
`endif

        if (m_idle) begin
            if (bus_if.iEN) begin m_idle = 0; m_arm = 1; m_pos = 0; end
        end else if (m_arm) begin
            m_arm = 0; m_pos = 0; m_stop = 0;
        end else if (last) begin
            m_pos = 0;
            if (m_stop) begin
                if (!bus_if.iEN) m_idle = 1;
                m_stop = 0;
            end else begin
                m_stop = !bus_if.iEN;
            end
        end else begin
            m_pos++;
            if (!bus_if.iEN) m_stop = 1;
        end
    endtask

    // One clock: apply stimulus on the falling edge, then evaluate the model
    task automatic tick();
        @(negedge clk);
        if (pop_pending) head = head + 1'b1;
        pop_pending = 0;
        rst_n                 = rst_v;
        bus_if.iEN            = en_v;
        bus_if.iPIX_VALID     = valid_v;
        bus_if.iPIX_DATA      = head;
        bus_if.iUNDERFLOW_CLR = clr_v;
`ifdef DVI_TESTPAT_EN
        bus_if.iTESTPAT       = tp_v;
`endif
        #1;
        model_eval();
    endtask

    task automatic wait_pos(input int p);
        int b;
        b = 0;
        while (!(!m_idle && !m_arm && m_pos == p)) begin
            tick();
            b++;
            if (b > 3 * FRAME) begin
                n_cmp++; n_err++;
                $display("FAIL wait_pos: position %0d not reached, got %0d", p, m_pos);
                break;
            end
        end
    endtask

    // Monitor: compare registered outputs against the scoreboard after every edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("de",        bus_if.oDE, e.de);
                check("hs",        bus_if.oHS, e.hs);
                check("vs",        bus_if.oVS, e.vs);
                check("rgb",       {bus_if.oRED, bus_if.oGRN, bus_if.oBLU}, e.rgb);
                check("underflow", bus_if.oUNDERFLOW, e.und);
            end else if (started) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard: no expectation queued, got de=%0b", bus_if.oDE);
            end
        end
    end

    initial begin : stim
        int x, y, b;
        bus_if.iEN = 0; bus_if.iPIX_VALID = 1; bus_if.iPIX_DATA = 0;
        bus_if.iUNDERFLOW_CLR = 0;
`ifdef DVI_TESTPAT_EN
        bus_if.iTESTPAT = 0;
`endif
        head = 24'($urandom);
        #1 rst_n = 1'b0;

        // reset held, then run with an always-valid FIFO
        repeat (4) tick();
        rst_v = 1; en_v = 1; valid_v = 1;
        repeat (2 * FRAME + 5) tick();

        // underflow on pixels 5..8 of line 2; clear collides with underflow, then clears alone
        wait_pos(0);
        for (int c = 0; c < FRAME; c++) begin
            x = m_pos % HT; y = m_pos / HT;
            valid_v = !(y == 2 && x >= 5 && x <= 8);
            clr_v   = (y == 2 && x == 7) || (y == 3 && x == 20);
            tick();
        end
        valid_v = 1; clr_v = 0;

        // drop run request at line 2: frame completes, then idle with no SOF
        wait_pos(2 * HT);
        en_v = 0;
        b = 0;
        while (!m_idle && b < 2 * FRAME) begin tick(); b++; end
        check("stop_to_idle", m_idle, 1);
        repeat (10) tick();

        // restart, drop, then re-raise during STOP for a back-to-back frame
        en_v = 1;
        wait_pos(HT);
        en_v = 0;
        wait_pos(3 * HT);
        en_v = 1;
        wait_pos(0);
        check("back_to_back", bus_if.oBUSY, 1);
        repeat (FRAME / 2) tick();

        // asynchronous reset in the middle of an active line, then restart
        wait_pos(HT + 5);
        rst_v = 0;
        repeat (3) tick();
        rst_v = 1;
        repeat (FRAME + 10) tick();

        // randomized run-request, FIFO-valid, clear and pattern requests
        en_v = 1;
        for (int c = 0; c < 12 * FRAME; c++) begin
            if ($urandom_range(0, 299) == 0) en_v = !en_v;
            valid_v = ($urandom_range(0, 9) != 0);
            clr_v   = ($urandom_range(0, 49) == 0);
            tp_v    = $urandom_range(0, 1) == 1;
            tick();
        end
        en_v = 1; valid_v = 1; clr_v = 0; tp_v = 0;

`ifdef DVI_TESTPAT_EN
        // colour bars for two whole frames
        tp_v = 1;
        wait_pos(FRAME - 1);
        repeat (2 * FRAME) tick();
        tp_v = 0;
`endif
        repeat (FRAME + 5) tick();

        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dvi_timing_ctrl.md
Name: dvi_timing_ctrl

Overview:
- Video timing controller and pixel sequencer feeding the DVI/TMDS output stage, on the pixel clock domain.
- Generates HS/VS/DE and 24-bit RGB from programmable timing.
- Pulls pixels from a show-ahead pixel FIFO through a read handshake and issues a start-of-frame pulse so the pixel source can resync.
- Handles FIFO underflow and clean start/stop at frame boundaries.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of oHS
- VS_POL, 0, active level of oVS

Ports:
- iCLK  in  1  pixel clock
- iRESETn  in  1  asynchronous active-low reset
- iEN  in  1  run request; level-sensitive
- iPIX_DATA  in  24  {R,G,B} from show-ahead FIFO head
- iPIX_VALID  in  1  FIFO not empty
- oPIX_RD  out  1  FIFO pop; pixel consumed this cycle
- oSOF  out  1  one-cycle start-of-frame pulse
- oRED/oGRN/oBLU  out  8 each  pixel to TMDS encoders
- oHS, oVS, oDE  out  1 each  sync and data enable to TMDS encoders
- oUNDERFLOW  out  1  sticky underflow flag
- iUNDERFLOW_CLR  in  1  clears oUNDERFLOW
- oBUSY  out  1  high in any state other than IDLE

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: hcnt 0..H_TOTAL-1; vcnt 0..V_TOTAL-1. hcnt wraps to 0 and vcnt increments at hcnt = H_TOTAL-1. vcnt wraps at V_TOTAL-1. Counter widths are clog2 of the totals.
- Regions:
  - de_c = hcnt < H_ACTIVE && vcnt < V_ACTIVE
  - hs_c = H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC
  - vs_c uses the same rule on vcnt and changes at hcnt = 0.
- Outputs are registered with 1-cycle latency from the counters:
  - oDE = de_c
  - oHS = hs_c ? HS_POL : !HS_POL
  - oVS = vs_c ? VS_POL : !VS_POL
  - RGB is iPIX_DATA sampled when de_c.
- Handshake:
  - oPIX_RD = de_c && iPIX_VALID && state in {RUN, STOP}. It is combinational and the same cycle as the sample.
  - oPIX_RD is never asserted when iPIX_VALID = 0.
- Underflow:
  - de_c with iPIX_VALID = 0 outputs RGB 0x000000 for that pixel and sets oUNDERFLOW.
  - Timing continues unchanged.
  - Set and iUNDERFLOW_CLR in the same cycle: set wins.
- FSM states:
  - IDLE: counters held at 0; oDE = 0; oHS/oVS inactive; RGB 0. iEN = 1 -> ARM.
  - ARM: one cycle; oSOF = 1 -> RUN with counters at (0,0).
  - RUN: counters free-run. oSOF = 1 in the cycle where hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1. iEN = 0 -> STOP.
  - STOP: as RUN. At the last cycle of the frame: if iEN = 0 -> IDLE (no oSOF); if iEN = 1 -> RUN (oSOF pulses, no gap).
- iEN toggling mid-frame never truncates a frame. A frame always completes once started.
- Reset state:
  - state IDLE; counters 0
  - oDE 0, oHS !HS_POL, oVS !VS_POL
  - RGB 0, oPIX_RD 0, oSOF 0, oUNDERFLOW 0, oBUSY 0
- Reset mid-frame aborts immediately to the reset state.

Optional Feature:
- Macro: DVI_TESTPAT_EN.
- Defined:
  - Adds input iTESTPAT (1 bit), sampled at frame start (ARM, or the oSOF cycle) and held for the whole frame.
  - When set: RGB = 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in order white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
  - When set: oPIX_RD is held 0 and no underflow is flagged.
- Undefined: port absent; pixels always come from the FIFO.

Test Plan (default 640x480, H_TOTAL 800, V_TOTAL 525):
- Reset release, iEN = 1, FIFO always valid:
  - oSOF pulses once, then every 420000 cycles.
  - oDE high for 640 cycles per line, 480 lines.
  - oHS low for 96 cycles starting 656 cycles after each line's first DE.
  - oVS low for 2 lines starting at line 490.
  - Exactly 307200 oPIX_RD per frame.
- FIFO data = incrementing counter: oRED/oGRN/oBLU equal the popped data 1 cycle after each oPIX_RD, with no skipped or duplicated values.
- iPIX_VALID = 0 for pixels 100..103 of line 5:
  - those 4 pixels output 0x000000; oPIX_RD low; oUNDERFLOW = 1 and sticky.
  - iUNDERFLOW_CLR clears it; clear concurrent with a new underflow leaves it 1.
- iEN dropped at line 200:
  - frame completes to cycle 419999, then IDLE with oBUSY = 0 and no oSOF.
  - Re-raising iEN during STOP gives a back-to-back frame with oSOF.
- iRESETn asserted mid-active-line: all outputs take reset values asynchronously; a restart after release begins at (0,0) with oSOF.
- With DVI_TESTPAT_EN, iTESTPAT = 1:
  - pixel 0 = 0xFFFFFF, pixel 80 = 0xFFFF00, pixel 560 = 0x000000.
  - oPIX_RD is never asserted.
